// File: rtl/sata_link_rx_frame_pkg.sv
// rtl/sata_link_rx_frame_pkg.sv - shared SATA link types, CRC constants and rx-frame FSM states
package sata_link_rx_frame_pkg;

  typedef enum logic [4:0] {
    is_none, is_dat, is_sof, is_eof, is_hold, is_holda, is_align, is_cont,
    is_r_ip, is_x_rdy, is_wtrm, is_r_rdy, is_r_ok, is_r_err, is_sync, is_err,
    is_dmat, is_pmreq_p, is_pmreq_s, is_pmack, is_pmnak
  } sata_p_t;

  localparam logic [31:0] SATA_CRC_INIT = 32'h52325032;
  localparam logic [31:0] SATA_CRC_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_state_t;

endpackage

// File: rtl/sata_link_crc.sv
// rtl/sata_link_crc.sv - combinational 32-bit-parallel CRC-32 step, MSB-first, shared with the TX framer
module sata_link_crc
  import sata_link_rx_frame_pkg::*;
#(
  parameter logic [31:0] POLY = SATA_CRC_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [31:0] dat,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ dat[i]) ? POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/sata_link_rx_frame.sv
// rtl/sata_link_rx_frame.sv - SOF/EOF frame extractor with CRC strip and sop/eop/err payload stream
// Optional per-outcome frame counters: define SATA_LINK_RX_STAT_EN.
module sata_link_rx_frame
  import sata_link_rx_frame_pkg::*;
#(
  parameter int          MAX_DW   = 2049,
  parameter logic [31:0] CRC_INIT = SATA_CRC_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  sata_p_t     dat_type,
  input  logic [31:0] dat_i,
  input  logic        m_afull,
  output logic        m_vld,
  output logic [31:0] m_dat,
  output logic        m_sop,
  output logic        m_eop,
  output logic        m_err,
  output logic        hold_req,
  output logic        st_vld,
  output logic        st_crc_err,
  output logic        st_abort,
  output logic [11:0] st_len
`ifdef SATA_LINK_RX_STAT_EN
  ,
  output logic [31:0] st_good_cnt,
  output logic [31:0] st_crc_cnt,
  output logic [31:0] st_abort_cnt
`endif
);

  if (MAX_DW < 1 || MAX_DW > 4095) begin : g_max_dw_chk
    $error("MAX_DW must be within 1..4095");
  end

  localparam logic [11:0] MAX_DW_W = 12'(MAX_DW);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  rx_state_t   state_q, state_d;
  logic [31:0] h0_q, h0_d, h1_q, h1_d, crc_q, crc_d, crc_step;
  logic [1:0]  cnt_q, cnt_d;
  logic [11:0] len_q, len_d, dcnt_q, dcnt_d;
  logic        sop_q, sop_d;
  logic        m_vld_d, m_sop_d, m_eop_d, m_err_d, hold_req_d;
  logic [31:0] m_dat_d;
  logic        st_vld_d, st_crc_err_d, st_abort_d;
  logic [11:0] st_len_d;
  logic        do_abort, do_fresh;

  sata_link_crc u_crc (
    .crc_in  (crc_q),
    .dat     (h0_q),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      h0_q       <= '0;
      h1_q       <= '0;
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      len_q      <= '0;
      dcnt_q     <= '0;
      sop_q      <= 1'b0;
      m_vld      <= 1'b0;
      m_dat      <= '0;
      m_sop      <= 1'b0;
      m_eop      <= 1'b0;
      m_err      <= 1'b0;
      hold_req   <= 1'b0;
      st_vld     <= 1'b0;
      st_crc_err <= 1'b0;
      st_abort   <= 1'b0;
      st_len     <= '0;
    end else begin
      state_q    <= state_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      dcnt_q     <= dcnt_d;
      sop_q      <= sop_d;
      m_vld      <= m_vld_d;
      m_dat      <= m_dat_d;
      m_sop      <= m_sop_d;
      m_eop      <= m_eop_d;
      m_err      <= m_err_d;
      hold_req   <= hold_req_d;
      st_vld     <= st_vld_d;
      st_crc_err <= st_crc_err_d;
      st_abort   <= st_abort_d;
      st_len     <= st_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    h0_d         = h0_q;
    h1_d         = h1_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    dcnt_d       = dcnt_q;
    sop_d        = sop_q;
    m_vld_d      = 1'b0;
    m_dat_d      = '0;
    m_sop_d      = 1'b0;
    m_eop_d      = 1'b0;
    m_err_d      = 1'b0;
    st_vld_d     = 1'b0;
    st_crc_err_d = 1'b0;
    st_abort_d   = 1'b0;
    st_len_d     = '0;
    hold_req_d   = (state_q == RX_RECV) && m_afull;
    do_abort     = 1'b0;
    do_fresh     = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (dat_type == is_sof) begin
          state_d  = RX_RECV;
          do_fresh = 1'b1;
        end
      end
      RX_RECV: begin
        case (dat_type)
          is_dat: begin
            if (dcnt_q == MAX_DW_W) begin
              do_abort = 1'b1;
              state_d  = RX_DROP;
            end else begin
              dcnt_d = dcnt_q + 12'd1;
              // h1 always holds the newest word, so the final one is the CRC
              if (cnt_q == 2'd2) begin
                m_vld_d = 1'b1;
                m_sop_d = !sop_q;
                m_dat_d = h0_q;
                sop_d   = 1'b1;
                crc_d   = crc_step;
                h0_d    = h1_q;
                h1_d    = dat_i;
                len_d   = sat_inc(len_q);
              end else if (cnt_q == 2'd1) begin
                h1_d  = dat_i;
                cnt_d = 2'd2;
              end else begin
                h0_d  = dat_i;
                cnt_d = 2'd1;
              end
            end
          end
          is_eof: begin
            state_d  = RX_IDLE;
            st_vld_d = 1'b1;
            if (cnt_q == 2'd2) begin
              m_vld_d      = 1'b1;
              m_sop_d      = !sop_q;
              m_eop_d      = 1'b1;
              m_dat_d      = h0_q;
              m_err_d      = (crc_step != h1_q);
              st_crc_err_d = (crc_step != h1_q);
              st_len_d     = sat_inc(len_q);
            end else begin
              st_abort_d = 1'b1;
            end
          end
          is_sync, is_err: begin
            do_abort = 1'b1;
            state_d  = RX_IDLE;
          end
          is_dmat: begin
            do_abort = 1'b1;
            state_d  = RX_DROP;
          end
          is_sof: begin
            do_abort = 1'b1;
            do_fresh = 1'b1;
          end
          default: ;
        endcase
      end
      RX_DROP: begin
        if (dat_type == is_eof || dat_type == is_sync) begin
          state_d = RX_IDLE;
        end else if (dat_type == is_sof) begin
          state_d  = RX_RECV;
          do_fresh = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (do_abort) begin
      st_vld_d   = 1'b1;
      st_abort_d = 1'b1;
      st_len_d   = len_q;
      if (sop_q) begin
        m_vld_d = 1'b1;
        m_eop_d = 1'b1;
        m_err_d = 1'b1;
        m_dat_d = '0;
      end
    end
    if (do_fresh) begin
      crc_d  = CRC_INIT;
      cnt_d  = '0;
      len_d  = '0;
      dcnt_d = '0;
      sop_d  = 1'b0;
    end
  end

`ifdef SATA_LINK_RX_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_good_cnt  <= '0;
      st_crc_cnt   <= '0;
      st_abort_cnt <= '0;
    end else if (st_vld) begin
      if (st_abort)        st_abort_cnt <= st_abort_cnt + 32'd1;
      else if (st_crc_err) st_crc_cnt   <= st_crc_cnt + 32'd1;
      else                 st_good_cnt  <= st_good_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sata_link_rx_frame.sv
// tb/tb_sata_link_rx_frame.sv - scoreboard bench for sata_link_rx_frame
module tb_sata_link_rx_frame;
  import sata_link_rx_frame_pkg::*;

  typedef struct packed {
    logic [31:0] dat;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  typedef struct packed {
    logic        crc_err;
    logic        abort;
    logic [11:0] len;
    logic        chk_len;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst;
  sata_p_t     dat_type;
  logic [31:0] dat_i;
  logic        m_afull;
  logic        m_vld, m_sop, m_eop, m_err, hold_req;
  logic [31:0] m_dat;
  logic        st_vld, st_crc_err, st_abort;
  logic [11:0] st_len;
`ifdef SATA_LINK_RX_STAT_EN
  logic [31:0] st_good_cnt, st_crc_cnt, st_abort_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  beat_t bq[$];
  stat_t sq[$];
  beat_t eb;
  stat_t es;
  logic [31:0] w0, w1, w2, c;

  always #5 clk = ~clk;

  sata_link_rx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .dat_type   (dat_type),
    .dat_i      (dat_i),
    .m_afull    (m_afull),
    .m_vld      (m_vld),
    .m_dat      (m_dat),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .m_err      (m_err),
    .hold_req   (hold_req),
    .st_vld     (st_vld),
    .st_crc_err (st_crc_err),
    .st_abort   (st_abort),
    .st_len     (st_len)
`ifdef SATA_LINK_RX_STAT_EN
    ,
    .st_good_cnt  (st_good_cnt),
    .st_crc_cnt   (st_crc_cnt),
    .st_abort_cnt (st_abort_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] x;
    x = crc ^ d;
    repeat (32) x = x[31] ? ((x << 1) ^ 32'h04C11DB7) : (x << 1);
    return x;
  endfunction

  task automatic push_beat(input logic [31:0] d, input logic s, input logic e, input logic r);
    beat_t b;
    b.dat = d; b.sop = s; b.eop = e; b.err = r;
    bq.push_back(b);
  endtask

  task automatic push_stat(input logic ce, input logic ab, input logic [11:0] len, input logic cl);
    stat_t s;
    s.crc_err = ce; s.abort = ab; s.len = len; s.chk_len = cl;
    sq.push_back(s);
  endtask

  task automatic drive(input sata_p_t t, input logic [31:0] d);
    @(posedge clk);
    #1;
    dat_type = t;
    dat_i    = d;
  endtask

  // n payload words, then CRC (bit 0 flipped when bad), then eof
  task automatic run_frame(input int n, input bit bad, input bit with_sof);
    logic [31:0] cr, w;
    cr = 32'h52325032;
    if (with_sof) drive(is_sof, 32'h0);
    for (int i = 0; i < n; i++) begin
      w  = $urandom;
      cr = crc_ref(cr, w);
      push_beat(w, i == 0, i == n - 1, (i == n - 1) && bad);
      drive(is_dat, w);
    end
    if (n >= 1) push_stat(bad, 1'b0, 12'(n), 1'b1);
    else        push_stat(1'b0, 1'b1, 12'd0, 1'b1);
    drive(is_dat, bad ? (cr ^ 32'h1) : cr);
    drive(is_eof, 32'h0);
    drive(is_align, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_vld) begin
        if (bq.size() == 0) check("beat_extra", {m_dat, m_sop, m_eop, m_err}, 64'h0);
        else begin
          eb = bq.pop_front();
          check("beat", {m_dat, m_sop, m_eop, m_err}, {eb.dat, eb.sop, eb.eop, eb.err});
        end
      end
      if (st_vld) begin
        if (sq.size() == 0) check("stat_extra", {st_crc_err, st_abort, st_len}, 64'h0);
        else begin
          es = sq.pop_front();
          if (es.chk_len) check("stat", {st_crc_err, st_abort, st_len}, {es.crc_err, es.abort, es.len});
          else            check("stat_abort", {st_crc_err, st_abort}, {es.crc_err, es.abort});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; dat_type = is_align; dat_i = '0; m_afull = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {m_vld, m_sop, m_eop, m_err, m_dat, hold_req, st_vld, st_crc_err, st_abort, st_len}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;

    m_afull = 1'b1;
    drive(is_align, 32'h0);
    drive(is_align, 32'h0);
    check("hold_idle", hold_req, 1'b0);
    m_afull = 1'b0;

    run_frame(4, 1'b0, 1'b1);
    run_frame(4, 1'b1, 1'b1);
    run_frame(1, 1'b0, 1'b1);

    // paused frame with hold_req following m_afull
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    c = crc_ref(crc_ref(crc_ref(32'h52325032, w0), w1), w2);
    push_beat(w0, 1'b1, 1'b0, 1'b0);
    push_beat(w1, 1'b0, 1'b0, 1'b0);
    push_beat(w2, 1'b0, 1'b1, 1'b0);
    push_stat(1'b0, 1'b0, 12'd3, 1'b1);
    m_afull = 1'b1;
    drive(is_sof, 32'h0);
    drive(is_dat, w0);
    repeat (5) drive(is_hold, 32'hDEAD0000);
    check("hold_recv", hold_req, 1'b1);
    drive(is_dat, w1);
    repeat (3) drive(is_holda, 32'hBEEF0000);
    drive(is_dat, w2);
    drive(is_dat, c);
    drive(is_eof, 32'h0);
    m_afull = 1'b0;
    drive(is_align, 32'h0);
    drive(is_align, 32'h0);
    check("hold_after", hold_req, 1'b0);

    // sync abort after one beat, then a good frame
    w0 = $urandom;
    push_beat(w0, 1'b1, 1'b0, 1'b0);
    push_beat(32'h0, 1'b0, 1'b1, 1'b1);
    push_stat(1'b0, 1'b1, 12'd0, 1'b0);
    drive(is_sof, 32'h0);
    drive(is_dat, w0);
    drive(is_dat, $urandom);
    drive(is_dat, $urandom);
    drive(is_sync, 32'h0);
    run_frame(3, 1'b0, 1'b1);

    // sof inside a frame restarts it
    w0 = $urandom;
    push_beat(w0, 1'b1, 1'b0, 1'b0);
    push_beat(32'h0, 1'b0, 1'b1, 1'b1);
    push_stat(1'b0, 1'b1, 12'd0, 1'b0);
    drive(is_sof, 32'h0);
    drive(is_dat, w0);
    drive(is_dat, $urandom);
    drive(is_dat, $urandom);
    run_frame(2, 1'b0, 1'b1);

    // overflow: 2050 data words, abort on the last, DROP until eof
    drive(is_sof, 32'h0);
    for (int i = 0; i < 2050; i++) begin
      w0 = $urandom;
      if (i < 2047) push_beat(w0, i == 0, 1'b0, 1'b0);
      if (i == 2049) begin
        push_beat(32'h0, 1'b0, 1'b1, 1'b1);
        push_stat(1'b0, 1'b1, 12'd0, 1'b0);
      end
      drive(is_dat, w0);
    end
    drive(is_dat, $urandom);
    drive(is_hold, 32'h0);
    drive(is_dat, $urandom);
    drive(is_eof, 32'h0);
    run_frame(4, 1'b0, 1'b1);

    // CRC-only and empty frames
    run_frame(0, 1'b0, 1'b1);
    push_stat(1'b0, 1'b1, 12'd0, 1'b1);
    drive(is_sof, 32'h0);
    drive(is_eof, 32'h0);
    drive(is_align, 32'h0);

    // reset mid-frame drops the frame silently
    m_afull = 1'b1;
    drive(is_sof, 32'h0);
    drive(is_dat, $urandom);
    drive(is_dat, $urandom);
    drive(is_hold, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {m_vld, m_sop, m_eop, m_err, m_dat, hold_req, st_vld, st_crc_err, st_abort, st_len}, 64'h0);
    m_afull = 1'b0;
    dat_type = is_align;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) drive(is_align, 32'h0);
    run_frame(5, 1'b0, 1'b1);
    run_frame(2, 1'b1, 1'b1);

    repeat (10) @(posedge clk);
    check("beat_q_left", bq.size(), 0);
    check("stat_q_left", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
